// File: rtl/wb_master_pkg.sv
// wb_master_pkg
// Shared definitions for the single-outstanding Wishbone classic master:
// controller state encoding, default bus geometry and timeout, and the
// command record (we/sel/adr/dat) at the default bus widths.
// No ports (package).
package wb_master_pkg;

  localparam int unsigned WB_AW      = 32;
  localparam int unsigned WB_DW      = 32;
  localparam int unsigned WB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Command record at the default widths; other initiators can use it
  // directly when they run at the default geometry.
  typedef struct packed {
    logic                   we;
    logic [WB_DW/8-1:0]     sel;
    logic [WB_AW-1:0]       adr;
    logic [WB_DW-1:0]       dat;
  } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr
// Saturating cycle counter for bus-cycle timeouts.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   clr    in  restart counting from zero (wins over en)
//   en     in  count one more cycle (saturates at all-ones)
//   expire out registered; high while the count equals LIMIT-1.
//              Never asserts when LIMIT is 0 (timeout disabled).
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // A zero LIMIT still needs a legal 1-bit counter.
  localparam int unsigned CW = (LIMIT > 32'd0) ? $clog2(LIMIT + 32'd1) : 1;

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic          expire_r;
  logic          expire_s;

  // Next count and the expire flag it implies, so expire comes from a flop.
  always_comb begin
    count_s  = count_r;
    expire_s = 1'b0;
    if (clr) begin
      count_s = {CW{1'b0}};
    end else if (en && (count_r != {CW{1'b1}})) begin
      count_s = count_r + CW'(1'b1);
    end else begin
      count_s = count_r;
    end
    expire_s = (LIMIT != 32'd0) && (count_s == CW'(LIMIT - 32'd1));
  end

  // Counter and expire registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CW{1'b0}};
      expire_r <= 1'b0;
    end else begin
      count_r  <= count_s;
      expire_r <= expire_s;
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/wb_master_seq.sv
// wb_master_seq
// Single-outstanding Wishbone classic master. Accepts one command on a
// valid/ready stream, runs one bus cycle, and returns read data or a timeout
// error on a valid/ready response stream. All outputs come from flops.
// DW must be a multiple of 8.
// Ports:
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake
//   cmd_we_i/sel_i/adr_i/dat_i      command fields
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_dat_o, rsp_err_o            read data (0 for writes/errors), timeout flag
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o  Wishbone master outputs
//   wbm_ack_i, wbm_dat_i            Wishbone slave acknowledge and read data
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int unsigned AW      = WB_AW,
  parameter int unsigned DW      = WB_DW,
  parameter int unsigned TIMEOUT = WB_TIMEOUT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  localparam int unsigned SW    = DW / 8;
  localparam int unsigned CMD_W = 1 + SW + AW + DW;

  // Same shape as wb_cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } cmd_t;

  wb_state_e     state_r;
  wb_state_e     state_s;
  cmd_t          cmd_r;
  cmd_t          cmd_s;
  logic [DW-1:0] rsp_dat_r;
  logic [DW-1:0] rsp_dat_s;
  logic          rsp_err_r;
  logic          rsp_err_s;
  logic          cyc_r;
  logic          cyc_s;
  logic          cmd_ready_r;
  logic          cmd_ready_s;
  logic          rsp_valid_r;
  logic          rsp_valid_s;
  logic          ctr_clr_s;
  logic          ctr_en_s;
  logic          ctr_expire_s;

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clr    (ctr_clr_s),
    .en     (ctr_en_s),
    .expire (ctr_expire_s)
  );

  // Next-state logic; the handshake outputs are decoded from the next state
  // so they can be registered without adding a cycle of latency.
  always_comb begin
    state_s   = state_r;
    cmd_s     = cmd_r;
    rsp_dat_s = rsp_dat_r;
    rsp_err_s = rsp_err_r;
    ctr_clr_s = 1'b0;
    ctr_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_r) begin
          cmd_s.we  = cmd_we_i;
          cmd_s.sel = cmd_sel_i;
          cmd_s.adr = cmd_adr_i;
          cmd_s.dat = cmd_dat_i;
          ctr_clr_s = 1'b1;
          state_s   = BUS;
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        // Ack beats an expiring counter in the same cycle.
        if (wbm_ack_i) begin
          rsp_dat_s = cmd_r.we ? {DW{1'b0}} : wbm_dat_i;
          rsp_err_s = 1'b0;
          state_s   = RESP;
        end else if (ctr_expire_s) begin
          rsp_dat_s = {DW{1'b0}};
          rsp_err_s = 1'b1;
          state_s   = RESP;
        end else begin
          ctr_en_s = 1'b1;
          state_s  = BUS;
        end
      end
      RESP: begin
        if (rsp_ready_i && rsp_valid_r) begin
          rsp_dat_s = {DW{1'b0}};
          rsp_err_s = 1'b0;
          state_s   = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    cyc_s       = (state_s == BUS);
    cmd_ready_s = (state_s == IDLE);
    rsp_valid_s = (state_s == RESP);
  end

  // State, command and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r     <= IDLE;
      cmd_r       <= cmd_t'({CMD_W{1'b0}});
      rsp_dat_r   <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
      cyc_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_r       <= cmd_s;
      rsp_dat_r   <= rsp_dat_s;
      rsp_err_r   <= rsp_err_s;
      cyc_r       <= cyc_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
    end
  end

  assign cmd_ready_o = cmd_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_dat_o   = rsp_dat_r;
  assign rsp_err_o   = rsp_err_r;
  assign wbm_cyc_o   = cyc_r;
  assign wbm_stb_o   = cyc_r;
  assign wbm_we_o    = cmd_r.we;
  assign wbm_sel_o   = cmd_r.sel;
  assign wbm_adr_o   = cmd_r.adr;
  assign wbm_dat_o   = cmd_r.dat;

endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq
// Drives two masters (TIMEOUT=4 and TIMEOUT=3) from one stimulus set and
// checks the selected one against a transaction-level expectation: an ack
// after d wait cycles succeeds iff d < TIMEOUT, cyc lasts d+1 cycles on
// success or TIMEOUT cycles on timeout, read data is returned only for
// successful reads. Inputs change and outputs are sampled on the falling edge.
module tb_wb_master_seq;
  import wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_ready;
  logic        ack;
  logic [31:0] ack_dat;
  logic        use_b;

  logic a_cmd_ready, a_rsp_valid, a_rsp_err, a_cyc, a_stb, a_we;
  logic b_cmd_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we;
  logic [31:0] a_rsp_dat, a_adr, a_dat, b_rsp_dat, b_adr, b_dat;
  logic [3:0]  a_sel, b_sel;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_cyc, o_stb, o_we;
  logic [31:0] o_rsp_dat, o_adr, o_dat;
  logic [3:0]  o_sel;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wb_master_seq #(.AW(32), .DW(32), .TIMEOUT(4)) dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(a_cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(a_rsp_dat), .rsp_err_o(a_rsp_err),
    .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we), .wbm_sel_o(a_sel),
    .wbm_adr_o(a_adr), .wbm_dat_o(a_dat), .wbm_ack_i(ack), .wbm_dat_i(ack_dat)
  );

  wb_master_seq #(.AW(32), .DW(32), .TIMEOUT(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(b_rsp_dat), .rsp_err_o(b_rsp_err),
    .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we), .wbm_sel_o(b_sel),
    .wbm_adr_o(b_adr), .wbm_dat_o(b_dat), .wbm_ack_i(ack), .wbm_dat_i(ack_dat)
  );

  assign o_cmd_ready = use_b ? b_cmd_ready : a_cmd_ready;
  assign o_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = use_b ? b_rsp_err   : a_rsp_err;
  assign o_rsp_dat   = use_b ? b_rsp_dat   : a_rsp_dat;
  assign o_cyc       = use_b ? b_cyc       : a_cyc;
  assign o_stb       = use_b ? b_stb       : a_stb;
  assign o_we        = use_b ? b_we        : a_we;
  assign o_sel       = use_b ? b_sel       : a_sel;
  assign o_adr       = use_b ? b_adr       : a_adr;
  assign o_dat       = use_b ? b_dat       : a_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_cyc", o_cyc, 0);
    chk("rst_stb", o_stb, 0);
    chk("rst_we", o_we, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_adr", o_adr, 0);
    chk("rst_dat", o_dat, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_dat", o_rsp_dat, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
  endtask

  // One full transaction, entered and left on a falling edge with the
  // selected master idle. d = wait cycles before ack (-1 = never acks),
  // rd = slave read data, hold = cycles of response backpressure.
  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int d, input logic [31:0] rd,
                         input int hold);
    int          to;
    int          n;
    int          exp_n;
    logic        ok;
    logic [31:0] exp_dat;
    to      = use_b ? 3 : 4;
    ok      = (d >= 0) && (d < to);
    exp_n   = ok ? d + 1 : to;
    exp_dat = (ok && !we) ? rd : 32'd0;

    chk("cmd_ready_idle", o_cmd_ready, 1);
    chk("cyc_idle", o_cyc, 0);
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
    cmd_adr = $urandom; cmd_dat = $urandom;

    n = 0;
    while (o_cyc && n < to + 4) begin
      chk("stb_eq_cyc", o_stb, 1);
      chk("bus_we", o_we, we);
      chk("bus_sel", o_sel, sel);
      chk("bus_adr", o_adr, adr);
      chk("bus_dat", o_dat, dat);
      chk("cmd_ready_bus", o_cmd_ready, 0);
      ack     = (n == d);
      ack_dat = ack ? rd : $urandom;
      n++;
      @(negedge clk);
    end
    ack = 1'b0;
    chk("cyc_cycles", n, exp_n);
    chk("stb_low_resp", o_stb, 0);
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_err", o_rsp_err, !ok);
    chk("rsp_dat", o_rsp_dat, exp_dat);

    // A late ack during the response phase must change nothing.
    ack = 1'b1; ack_dat = $urandom;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
      cmd_adr = $urandom; cmd_dat = $urandom;
      @(negedge clk);
      ack = 1'b0;
      chk("bp_rsp_valid", o_rsp_valid, 1);
      chk("bp_rsp_err", o_rsp_err, !ok);
      chk("bp_rsp_dat", o_rsp_dat, exp_dat);
      chk("bp_cmd_ready", o_cmd_ready, 0);
      chk("bp_cyc", o_cyc, 0);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    ack = 1'b0; rsp_ready = 1'b0;
    chk("rsp_valid_drop", o_rsp_valid, 0);
    chk("cmd_ready_back", o_cmd_ready, 1);
    chk("cyc_after_rsp", o_cyc, 0);
  endtask

  initial begin
    rst_n = 1'b0; use_b = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    rsp_ready = 1'b0; ack = 1'b0; ack_dat = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // Write, slave acks two cycles after stb: cyc high 3 cycles.
    run_txn(1'b1, 4'hF, 32'h3000_0000, 32'h0000_00A5, 2, 32'hDEAD_BEEF, 0);
    // Zero-wait read.
    run_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0000_0000, 0, 32'h1234_5678, 0);
    // Timeout (TIMEOUT=4), late ack in RESP.
    run_txn(1'b0, 4'h3, 32'h3000_0008, 32'h0000_0000, -1, 32'h5555_AAAA, 0);
    // Response backpressure for 10 cycles with a pending command.
    run_txn(1'b0, 4'hF, 32'h3000_000C, 32'h0000_0000, 1, 32'hCAFE_F00D, 10);
    // Ack exactly on the last allowed cycle.
    run_txn(1'b0, 4'hC, 32'h3000_0010, 32'h0000_0000, 3, 32'h0BAD_F00D, 1);

    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 6)) - 1, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a bus cycle.
    chk("pre_rst_cmd_ready", o_cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0020; cmd_dat = 32'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_cyc", o_cyc, 1);
    @(negedge clk);
    chk("pre_rst_cyc2", o_cyc, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    run_txn(1'b0, 4'hF, 32'h3000_0024, 32'h0000_0000, 1, 32'h7777_1111, 0);

    // TIMEOUT=3 instance: ack on the expiring cycle wins.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; use_b = 1'b1;
    @(negedge clk);
    check_reset_values();
    run_txn(1'b0, 4'hF, 32'h3000_0030, 32'h0000_0000, 2, 32'h89AB_CDEF, 0);
    run_txn(1'b1, 4'h1, 32'h3000_0034, 32'h0000_0042, 2, 32'hFFFF_FFFF, 2);
    run_txn(1'b0, 4'hF, 32'h3000_0038, 32'h0000_0000, 3, 32'h1357_9BDF, 0);
    run_txn(1'b0, 4'hF, 32'h3000_003C, 32'h0000_0000, -1, 32'h2468_ACE0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
